// File: rtl/fft_input_loader_pkg.sv
// Shared definitions for the 8-point FFT pipeline: frame geometry, loader states and
// the 3-bit bit-reversal used for input loading and output reordering.
package fft_input_loader_pkg;

   localparam int FFT_POINTS = 8;
   localparam int FFT_LOG2   = 3;

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_HOLD  = 2'd1,
      ST_DRAIN = 2'd2
   } ld_state_e;

   function automatic int sample_width(input int n);
      return 2 ** n;
   endfunction

   function automatic logic [FFT_LOG2-1:0] bitrev3(input logic [FFT_LOG2-1:0] b);
      return {b[0], b[1], b[2]};
   endfunction

endpackage

// File: rtl/fft_input_loader.sv
// Collects 8 samples into bit-reversed lanes; frame_valid rises 1 clk after the 8th accept.
// Frame is held until frame_ready; one idle release cycle follows before refilling.
module fft_input_loader
   import fft_input_loader_pkg::*;
#(
   parameter int N = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [(2**N)-1:0]             in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [FFT_POINTS*(2**N)-1:0]  frame_data,
   output logic                          frame_valid,
   input  logic                          frame_ready,
   output logic [7:0]                    frame_count
);

   localparam int W = sample_width(N);

   ld_state_e                       state_q, state_d;
   logic [FFT_LOG2-1:0]             idx_q, idx_d;
   logic [FFT_POINTS-1:0][W-1:0]    buf_q, buf_d;
   logic [7:0]                      frame_count_q, frame_count_d;

   // Handshake outputs depend on state only, so no input-to-ready path exists.
   assign in_ready    = (state_q == ST_FILL);
   assign frame_valid = (state_q == ST_HOLD);
   assign frame_data  = buf_q;
   assign frame_count = frame_count_q;

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      buf_d         = buf_q;
      frame_count_d = frame_count_q;
      case (state_q)
         ST_FILL: begin
            if (in_valid) begin
               buf_d[bitrev3(idx_q)] = in_data;
               idx_d                 = idx_q + 3'd1;
               if (idx_q == 3'(FFT_POINTS - 1)) begin
                  state_d = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (frame_ready) begin
               state_d       = ST_DRAIN;
               frame_count_d = frame_count_q + 8'd1;
            end
         end
         ST_DRAIN: begin
            state_d = ST_FILL;
         end
         default: begin
            state_d = ST_FILL;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_FILL;
         idx_q         <= '0;
         buf_q         <= '0;
         frame_count_q <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         buf_q         <= buf_d;
         frame_count_q <= frame_count_d;
      end
   end

endmodule
